// File: rtl/uart_transceiver.sv
// 8N1 UART PHY: an oversampled receiver with start-bit glitch rejection and a
// single-byte transmitter, both paced by one shared baud tick.
module uart_transceiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic       received,
    output logic [7:0] data_received,
    output logic       frame_error,
    input  logic [7:0] data_transmit,
    input  logic       send,
    output logic       tx_ready
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

    // ------------------------------------------------------------------
    // Shared oversample tick
    // ------------------------------------------------------------------
    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DIV_LAST);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    // ------------------------------------------------------------------
    // RX synchroniser
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    // NOTE: the synchroniser resets to the idle line level, otherwise the
    // receiver would see a false start bit on the first cycles after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    rx_state_t     rx_state, rx_state_nx;
    logic [TW-1:0] rx_tick, rx_tick_nx;
    logic [2:0]    rx_bit, rx_bit_nx;
    logic [7:0]    rx_shift, rx_shift_nx;
    logic [7:0]    data_received_nx;
    logic          received_nx;
    logic          frame_error_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state      <= RX_IDLE;
            rx_tick       <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            data_received <= '0;
            received      <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            rx_state      <= rx_state_nx;
            rx_tick       <= rx_tick_nx;
            rx_bit        <= rx_bit_nx;
            rx_shift      <= rx_shift_nx;
            data_received <= data_received_nx;
            received      <= received_nx;
            frame_error   <= frame_error_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        rx_state_nx      = rx_state;
        rx_tick_nx       = rx_tick;
        rx_bit_nx        = rx_bit;
        rx_shift_nx      = rx_shift;
        data_received_nx = data_received;
        received_nx      = 1'b0;
        frame_error_nx   = 1'b0;

        unique case (rx_state)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_state_nx = RX_START;
                    rx_tick_nx  = '0;
                end
            end
            RX_START: begin
                // Re-check the line at mid start bit; a short low pulse is dropped.
                if (tick) begin
                    if (rx_tick == TICK_MID) begin
                        rx_tick_nx  = '0;
                        rx_bit_nx   = '0;
                        rx_state_nx = rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_nx = rx_tick + TW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tick == TICK_LAST) begin
                        rx_tick_nx  = '0;
                        rx_shift_nx = {rxs, rx_shift[7:1]};
                        rx_bit_nx   = rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
                    end else begin
                        rx_tick_nx = rx_tick + TW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_tick == TICK_LAST) begin
                        rx_tick_nx = '0;
                        if (rxs) begin
                            data_received_nx = rx_shift;
                            received_nx      = 1'b1;
                            rx_state_nx      = RX_IDLE;
                        end else begin
                            frame_error_nx = 1'b1;
                            rx_state_nx    = RX_BREAK;
                        end
                    end else begin
                        rx_tick_nx = rx_tick + TW'(1);
                    end
                end
            end
            RX_BREAK: begin
                if (rxs) rx_state_nx = RX_IDLE;
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t     tx_state, tx_state_nx;
    logic [TW-1:0] tx_tick, tx_tick_nx;
    logic [2:0]    tx_bit, tx_bit_nx;
    logic [7:0]    tx_shift, tx_shift_nx;
    logic          tx_nx;

    assign tx_ready = (tx_state == TX_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_tick  <= tx_tick_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
            tx       <= tx_nx;
        end
    end

    // The line level is registered from the next state so tx never glitches.
    always_comb begin
        tx_state_nx = tx_state;
        tx_tick_nx  = tx_tick;
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        tx_nx       = tx;

        unique case (tx_state)
            TX_IDLE: begin
                tx_nx = 1'b1;
                if (send) begin
                    tx_shift_nx = data_transmit;
                    tx_tick_nx  = '0;
                    tx_bit_nx   = '0;
                    tx_state_nx = TX_START;
                    tx_nx       = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_tick == TICK_LAST) begin
                        tx_tick_nx  = '0;
                        tx_state_nx = TX_DATA;
                        tx_nx       = tx_shift[0];
                    end else begin
                        tx_tick_nx = tx_tick + TW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tick == TICK_LAST) begin
                        tx_tick_nx = '0;
                        tx_bit_nx  = tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state_nx = TX_STOP;
                            tx_nx       = 1'b1;
                        end else begin
                            tx_shift_nx = {1'b0, tx_shift[7:1]};
                            tx_nx       = tx_shift[1];
                        end
                    end else begin
                        tx_tick_nx = tx_tick + TW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_tick == TICK_LAST) begin
                        tx_tick_nx  = '0;
                        tx_state_nx = TX_IDLE;
                        tx_nx       = 1'b1;
                    end else begin
                        tx_tick_nx = tx_tick + TW'(1);
                    end
                end
            end
            default: begin
                tx_state_nx = TX_IDLE;
                tx_nx       = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: directed frames plus randomised
// simultaneous RX/TX traffic against a frame-level reference model.
module tb_uart_transceiver;

    localparam int CLK_FREQ   = 16_000_000;
    localparam int BAUD       = 1_000_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT        = 16;  // clks per bit with DIV = 1

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       tx;
    logic       received;
    logic [7:0] data_received;
    logic       frame_error;
    logic [7:0] data_transmit;
    logic       send;
    logic       tx_ready;

    uart_transceiver #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .tx           (tx),
        .received     (received),
        .data_received(data_received),
        .frame_error  (frame_error),
        .data_transmit(data_transmit),
        .send         (send),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    logic [7:0] got_rx_q[$];
    int rx_cnt      = 0;
    int fe_cnt      = 0;
    int both_cnt    = 0;
    int last_rx_cyc = 0;

    always @(negedge clk) begin
        if (received) begin
            got_rx_q.push_back(data_received);
            rx_cnt++;
            last_rx_cyc = cyc;
        end
        if (frame_error) fe_cnt++;
        if (received && frame_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level receive model: good frames deliver their byte, bad stop bits
    // count a framing error and leave the last byte alone.
    logic [7:0] exp_rx_q[$];
    logic [7:0] last_good = 8'h00;
    int         exp_fe    = 0;

    task automatic model_rx_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_rx_q.push_back(b);
            last_good = b;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, got_rx_q.size(), exp_rx_q.size());
        while (exp_rx_q.size() > 0 && got_rx_q.size() > 0)
            check({tag, "_rx_byte"}, got_rx_q.pop_front(), exp_rx_q.pop_front());
        exp_rx_q.delete();
        got_rx_q.delete();
        check({tag, "_frame_errors"}, fe_cnt, exp_fe);
        check({tag, "_data_received"}, data_received, last_good);
        check({tag, "_no_overlap"}, both_cnt, 0);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (BIT) @(negedge clk);
        end
        repeat (extra_low) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_transmit = b;
        send          = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Waits for a start bit on tx and decodes the frame at mid-bit points.
    task automatic capture_tx(input string tag, output logic [7:0] b, output int start_cyc);
        int waited;
        waited = 0;
        b      = 8'h00;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_start_seen"}, tx, 0);
        start_cyc = cyc;
        repeat (BIT / 2) @(negedge clk);
        check({tag, "_start_bit"}, tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        check({tag, "_stop_bit"}, tx, 1);
    endtask

    task automatic wait_tx_ready(input string tag);
        int waited;
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_tx_ready"}, tx_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f;
        logic [7:0] b1, b2, rb, tb_byte, got;
        logic       ok;
        int         c0, c1, c2, cs, dly, lows, rx_before, fe_before;

        reset         = 1'b1;
        rx            = 1'b1;
        send          = 1'b0;
        data_transmit = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_received", received, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_data_received", data_received, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // TX waveform, cycle by cycle, with an ignored send while busy
        f = {1'b1, 8'h41, 1'b0};
        send_byte(8'h41);
        for (int k = 0; k < 10 * BIT; k++) begin
            check($sformatf("t1_tx_k%0d", k), tx, f[k / BIT]);
            check($sformatf("t1_busy_k%0d", k), tx_ready, 0);
            if (k == 50) begin
                data_transmit = 8'hFF;
                send          = 1'b1;
            end
            if (k == 51) send = 1'b0;
            @(negedge clk);
        end
        check("t1_ready_after", tx_ready, 1);
        lows = 0;
        repeat (30) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check("t1_no_queued_frame", lows, 0);

        // Glitch rejection, then a real frame
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check_rx("t3_glitch");
        drive_rx_frame(8'h5A, 1'b1, 0);
        model_rx_frame(8'h5A, 1'b1);
        check_rx("t3_frame");

        // Basic receive with latency window
        c0 = cyc;
        drive_rx_frame(8'hA5, 1'b1, 0);
        model_rx_frame(8'hA5, 1'b1);
        check("t2_latency", (last_rx_cyc - c0 >= 150) && (last_rx_cyc - c0 <= 158), 1);
        check_rx("t2");

        // Framing error with a held-low line, then recovery
        drive_rx_frame(8'h3C, 1'b0, 40);
        model_rx_frame(8'h3C, 1'b0);
        check_rx("t4_ferr");
        drive_rx_frame(8'h11, 1'b1, 0);
        model_rx_frame(8'h11, 1'b1);
        check_rx("t4_recover");

        // Back-to-back transmit with send held and data changed mid-frame
        fork
            begin
                data_transmit = 8'h55;
                send          = 1'b1;
                repeat (20) @(negedge clk);
                data_transmit = 8'hAA;
                repeat (200) @(negedge clk);
                send = 1'b0;
            end
            begin
                capture_tx("t5_f1", b1, c1);
                capture_tx("t5_f2", b2, c2);
            end
        join
        check("t5_first_byte", b1, 8'h55);
        check("t5_second_byte", b2, 8'hAA);
        check("t5_gap", c2 - c1, 10 * BIT + 1);
        wait_tx_ready("t5");
        lows = 0;
        repeat (40) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check("t5_no_third_frame", lows, 0);

        // Reset during TX bit 3 and RX bit 5
        rx_before = rx_cnt;
        fe_before = fe_cnt;
        fork
            drive_rx_frame(8'hC3, 1'b1, 0);
            begin
                repeat (30) @(negedge clk);
                send_byte(8'h96);
                repeat (69) @(negedge clk);
                reset = 1'b1;
                #1;
                check("t6_tx_async", tx, 1);
                check("t6_tx_ready_async", tx_ready, 1);
                check("t6_received_rst", received, 0);
                check("t6_frame_error_rst", frame_error, 0);
                check("t6_data_received_rst", data_received, 8'h00);
                repeat (75) @(negedge clk);
                reset = 1'b0;
            end
        join
        last_good = 8'h00;
        repeat (30) @(negedge clk);
        check("t6_no_rx_pulse", rx_cnt - rx_before, 0);
        check("t6_no_ferr_pulse", fe_cnt - fe_before, 0);
        check("t6_tx_idle", tx, 1);
        check_rx("t6_abort");
        fork
            drive_rx_frame(8'h7E, 1'b1, 0);
            begin
                send_byte(8'hC9);
                capture_tx("t6_tx", got, cs);
                wait_tx_ready("t6");
            end
        join
        model_rx_frame(8'h7E, 1'b1);
        check("t6_tx_byte", got, 8'hC9);
        check_rx("t6_after");

        // Randomised simultaneous receive and transmit
        for (int it = 0; it < 8; it++) begin
            rb      = 8'($urandom);
            tb_byte = 8'($urandom);
            ok      = ($urandom_range(0, 3) != 0);
            dly     = int'($urandom_range(0, 40));
            lows    = ok ? 0 : int'($urandom_range(1, 30));
            fork
                drive_rx_frame(rb, ok, lows);
                begin
                    repeat (dly) @(negedge clk);
                    send_byte(tb_byte);
                    capture_tx($sformatf("rnd%0d", it), got, cs);
                    wait_tx_ready($sformatf("rnd%0d", it));
                end
            join
            model_rx_frame(rb, ok);
            check($sformatf("rnd%0d_tx_byte", it), got, tb_byte);
            check_rx($sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
